// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RISC-V M-extension multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle.
// Ports:
//   clk, reset        - clock, async active-high reset
//   start, funct3     - request pulse and M-extension op select
//   X, Y              - rs1 / rs2 operands (N bits)
//   busy, done        - in-flight flag, one-cycle completion pulse
//   result            - registered result, held until next completion
module muldiv_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [2:0]      r_op;
    logic [N-1:0]    r_hi;
    logic [N-1:0]    r_lo;
    logic [N-1:0]    r_opd;
    logic [CW-1:0]   r_count;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_fast;
    logic [N-1:0]    r_result;

    logic            w_accept;
    logic            w_x_sgn;
    logic            w_y_sgn;
    logic            w_x_neg;
    logic            w_y_neg;
    logic [N-1:0]    w_x_mag;
    logic [N-1:0]    w_y_mag;
    logic            w_is_div;
    logic            w_dz;
    logic            w_ovf;
    logic            w_fast;
    logic [N-1:0]    w_fast_val;
    logic [N:0]      w_add;
    logic [N:0]      w_sh;
    logic [N:0]      w_sub;
    logic            w_ge;
    logic [2*N-1:0]  w_prod;
    logic [2*N-1:0]  w_prod_s;
    logic [N-1:0]    w_quot;
    logic [N-1:0]    w_rem;
    logic [N-1:0]    w_fin;

    // Operand signedness: MULH/DIV/REM both signed, MULHSU only X.
    assign w_x_sgn = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_y_sgn = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                     (funct3 == 3'b110);
    assign w_x_neg = w_x_sgn & X[N-1];
    assign w_y_neg = w_y_sgn & Y[N-1];
    assign w_x_mag = w_x_neg ? -X : X;
    assign w_y_mag = w_y_neg ? -Y : Y;

    assign w_is_div = funct3[2];
    assign w_dz     = w_is_div && (Y == '0);
    assign w_ovf    = w_is_div && !funct3[0] &&
                      (X == {1'b1, {(N-1){1'b0}}}) && (Y == '1);
    assign w_fast   = w_dz || w_ovf;

    // funct3[1] separates remainder from quotient among divides.
    always_comb begin
        w_fast_val = '0;
        if (w_dz) begin
            w_fast_val = funct3[1] ? X : '1;
        end else if (w_ovf) begin
            w_fast_val = funct3[1] ? '0 : X;
        end
    end

    assign w_accept = start &&
                      ((r_state == S_IDLE) || (r_state == S_DONE));

    // Shift-add step: carry out of the upper-half add shifts in on top.
    assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);

    // Restoring step on an N+1 bit partial remainder.
    assign w_sh  = {r_hi, r_lo[N-1]};
    assign w_ge  = (w_sh >= {1'b0, r_opd});
    assign w_sub = w_sh - {1'b0, r_opd};

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quot   = r_neg_q ? -r_lo : r_lo;
    assign w_rem    = r_neg_r ? -r_hi : r_hi;

    always_comb begin
        w_fin = '0;
        if (r_fast) begin
            w_fin = r_lo;
        end else if (r_op == 3'b000) begin
            w_fin = w_prod_s[N-1:0];
        end else if (!r_op[2]) begin
            w_fin = w_prod_s[2*N-1:N];
        end else if (!r_op[1]) begin
            w_fin = w_quot;
        end else begin
            w_fin = w_rem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = w_fast ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_count == CW'(N-1)) begin
                    w_state_nx = S_FIN;
                end
            end
            S_FIN: begin
                busy       = 1'b1;
                w_state_nx = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_nx = w_fast ? S_FIN : S_CALC;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_count  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_fast   <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= funct3;
            r_count <= '0;
            r_fast  <= w_fast;
            r_neg_q <= w_x_neg ^ w_y_neg;
            r_neg_r <= w_x_neg;
            r_hi    <= '0;
            if (w_fast) begin
                r_lo  <= w_fast_val;
                r_opd <= '0;
            end else if (w_is_div) begin
                r_lo  <= w_x_mag;
                r_opd <= w_y_mag;
            end else begin
                r_lo  <= w_y_mag;
                r_opd <= w_x_mag;
            end
        end else if (r_state == S_CALC) begin
            r_count <= r_count + 1'b1;
            if (r_op[2]) begin
                r_hi <= w_ge ? w_sub[N-1:0] : w_sh[N-1:0];
                r_lo <= {r_lo[N-2:0], w_ge};
            end else begin
                r_hi <= w_add[N:1];
                r_lo <= {w_add[0], r_lo[N-1:1]};
            end
        end else if (r_state == S_FIN) begin
            r_result <= w_fin;
        end
    end

    assign result = r_result;

endmodule
